// File: rtl/ex_stage_pkg.sv
// Shared types for the MINAv2 execute stage.
// Holds the decoded-instruction record (ex_params_t), the operand/ALU/T-flag/memory
// opcode enums, the EX FSM state type and two small helpers (forwarding and operand
// selection) used by ex_stage.
package ex_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {SEL_ZERO, SEL_REG, SEL_IMM, SEL_PC} sel_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_SAR
  } alu_op_t;

  typedef enum logic [2:0] {T_OP_NONE, T_OP_SET, T_OP_EQ, T_OP_LT, T_OP_LTU} t_op_t;

  typedef enum logic [1:0] {MEM_OP_NONE, MEM_OP_LOAD, MEM_OP_STORE} mem_op_t;

  typedef enum logic [0:0] {EX_RUN, EX_FLUSH} ex_state_t;

  typedef struct packed {
    logic [31:0]           ia_plus_4;
    logic [REG_ADDR_W-1:0] ra_addr;
    logic [REG_ADDR_W-1:0] rb_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [31:0]           ra_data;
    logic [31:0]           rb_data;
    logic [31:0]           imm;
    sel_t                  a_sel;
    sel_t                  b_sel;
    logic [1:0]            shift;
    logic                  invert_b;
    alu_op_t               alu_op;
    t_op_t                 t_op;
    logic                  invert_t;
    logic                  branch;
    logic                  cond_branch;
    mem_op_t               mem_op;
  } ex_params_t;

  // r0 is hardwired to zero; the younger producer (MEM) wins over WB.
  function automatic logic [31:0] fwd_operand(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [31:0]           rf_data,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_addr,
    input logic [31:0]           mem_data,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [31:0]           wb_data
  );
    logic [31:0] val;
    if (addr == '0) begin
      val = '0;
    end else if (mem_we && (mem_addr == addr)) begin
      val = mem_data;
    end else if (wb_we && (wb_addr == addr)) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // SEL_PC yields the address of the instruction itself.
  function automatic logic [31:0] sel_operand(
    input sel_t        sel,
    input logic [31:0] reg_val,
    input logic [31:0] imm,
    input logic [31:0] ia_plus_4
  );
    logic [31:0] val;
    case (sel)
      SEL_ZERO: val = '0;
      SEL_REG:  val = reg_val;
      SEL_IMM:  val = imm;
      SEL_PC:   val = ia_plus_4 - 32'd4;
      default:  val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// EX/MEM pipeline register bus.
// master (EX): drives mem_valid, mem_op, mem_rd_addr, mem_result, mem_store_data.
// slave  (MEM): samples the same signals.
interface ex_stage_if import ex_stage_pkg::*;;
  logic                  mem_valid;
  mem_op_t               mem_op;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic [31:0]           mem_result;
  logic [31:0]           mem_store_data;

  modport master (
    output mem_valid, mem_op, mem_rd_addr, mem_result, mem_store_data
  );

  modport slave (
    input mem_valid, mem_op, mem_rd_addr, mem_result, mem_store_data
  );
endinterface

// File: rtl/ex_alu.sv
// Combinational ALU and T-flag compare for the execute stage.
// Inputs : a_i, b_i (selected operands), shift_i (B left-shift), invert_b_i, alu_op_i,
//          t_op_i, invert_t_i.
// Outputs: result_o (ALU result), t_we_o (T write request), t_next_o (new T value).
module ex_alu import ex_stage_pkg::*; (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  shift_i,
  input  logic        invert_b_i,
  input  alu_op_t     alu_op_i,
  input  t_op_t       t_op_i,
  input  logic        invert_t_i,
  output logic [31:0] result_o,
  output logic        t_we_o,
  output logic        t_next_o
);

  logic [31:0] b_shifted;
  logic [31:0] b_eff;

  always_comb begin
    b_shifted = b_i << shift_i;
    b_eff     = invert_b_i ? ~b_shifted : b_shifted;

    result_o = '0;
    case (alu_op_i)
      // +invert_b turns the one's complement into a two's complement subtract.
      ALU_ADD: result_o = a_i + b_eff + {31'b0, invert_b_i};
      ALU_AND: result_o = a_i & b_eff;
      ALU_OR:  result_o = a_i | b_eff;
      ALU_XOR: result_o = a_i ^ b_eff;
      ALU_SHL: result_o = a_i << b_eff[4:0];
      ALU_SHR: result_o = a_i >> b_eff[4:0];
      ALU_SAR: result_o = $unsigned($signed(a_i) >>> b_eff[4:0]);
      default: result_o = '0;
    endcase
  end

  // Compares look at the raw operands, not the shifted/inverted B.
  always_comb begin
    t_we_o   = 1'b1;
    t_next_o = 1'b0;
    case (t_op_i)
      T_OP_NONE: t_we_o   = 1'b0;
      T_OP_SET:  t_next_o = invert_t_i;
      T_OP_EQ:   t_next_o = (a_i == b_i) ^ invert_t_i;
      T_OP_LT:   t_next_o = ($signed(a_i) < $signed(b_i)) ^ invert_t_i;
      T_OP_LTU:  t_next_o = (a_i < b_i) ^ invert_t_i;
      default:   t_we_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MINAv2 execute stage: operand forwarding, ALU, T-flag update, branch resolution and
// the EX/MEM pipeline register.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ex_params_i         decoded instruction from ID/EX
//   valid_o             0 = bubble ID/EX and IF/ID at the next edge (combinational)
//   fwd_mem_*_i         MEM-stage forwarding source
//   fwd_wb_*_i          WB-stage forwarding source
//   ex_mem_o            EX/MEM register bus (ex_stage_if.master)
//   redirect_valid_o    one-cycle fetch redirect pulse, redirect_addr_o its target
//   t_flag_o            architectural T flag
// Optional: define EX_PERF_COUNTERS_EN to add perf_taken_o (live taken branches) and
// perf_flush_o (cycles with valid_o low).
module ex_stage import ex_stage_pkg::*; #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  ex_params_t            ex_params_i,
  output logic                  valid_o,
  input  logic                  fwd_mem_we_i,
  input  logic [REG_ADDR_W-1:0] fwd_mem_addr_i,
  input  logic [31:0]           fwd_mem_data_i,
  input  logic                  fwd_wb_we_i,
  input  logic [REG_ADDR_W-1:0] fwd_wb_addr_i,
  input  logic [31:0]           fwd_wb_data_i,
  ex_stage_if.master            ex_mem_o,
  output logic                  redirect_valid_o,
  output logic [31:0]           redirect_addr_o,
  output logic                  t_flag_o
`ifdef EX_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_taken_o,
  output logic [31:0]           perf_flush_o
`endif
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES - 1);
  localparam logic [0:0] StRun   = EX_RUN;
  localparam logic [0:0] StFlush = EX_FLUSH;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            occupied_q;
  logic            t_flag_q;
  logic            redirect_valid_q;
  logic [31:0]     redirect_addr_q;

  logic        live;
  logic        taken;
  logic [31:0] ra_val, rb_val;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_result;
  logic        t_we, t_next;
  logic [31:0] target;

  // ID/EX is cleared whenever valid_o was low, so occupancy tracks it exactly.
  assign live = occupied_q;

  always_comb begin
    ra_val = fwd_operand(ex_params_i.ra_addr, ex_params_i.ra_data, fwd_mem_we_i,
                         fwd_mem_addr_i, fwd_mem_data_i, fwd_wb_we_i, fwd_wb_addr_i,
                         fwd_wb_data_i);
    rb_val = fwd_operand(ex_params_i.rb_addr, ex_params_i.rb_data, fwd_mem_we_i,
                         fwd_mem_addr_i, fwd_mem_data_i, fwd_wb_we_i, fwd_wb_addr_i,
                         fwd_wb_data_i);
    op_a   = sel_operand(ex_params_i.a_sel, ra_val, ex_params_i.imm, ex_params_i.ia_plus_4);
    op_b   = sel_operand(ex_params_i.b_sel, rb_val, ex_params_i.imm, ex_params_i.ia_plus_4);
  end

  ex_alu u_alu (
    .a_i        (op_a),
    .b_i        (op_b),
    .shift_i    (ex_params_i.shift),
    .invert_b_i (ex_params_i.invert_b),
    .alu_op_i   (ex_params_i.alu_op),
    .t_op_i     (ex_params_i.t_op),
    .invert_t_i (ex_params_i.invert_t),
    .result_o   (alu_result),
    .t_we_o     (t_we),
    .t_next_o   (t_next)
  );

  // Branch condition uses T as it stood before this instruction's own T update.
  assign taken  = live && ex_params_i.branch && (!ex_params_i.cond_branch || t_flag_q);
  assign target = {alu_result[31:2], 2'b00};

  assign valid_o = (state_q == StRun) && !taken;

  // The taken cycle itself is the first low cycle of valid_o; FLUSH covers the rest.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (taken) begin
          cnt_d   = CntInit;
          state_d = (CntInit != '0) ? StFlush : StRun;
        end
      end
      StFlush: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_d == '0) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                 <= StRun;
      cnt_q                   <= '0;
      occupied_q              <= 1'b0;
      t_flag_q                <= 1'b0;
      redirect_valid_q        <= 1'b0;
      redirect_addr_q         <= '0;
      ex_mem_o.mem_valid      <= 1'b0;
      ex_mem_o.mem_op         <= MEM_OP_NONE;
      ex_mem_o.mem_rd_addr    <= '0;
      ex_mem_o.mem_result     <= '0;
      ex_mem_o.mem_store_data <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      occupied_q       <= valid_o;
      redirect_valid_q <= taken;
      if (taken) redirect_addr_q <= target;
      if (live && t_we) t_flag_q <= t_next;
      ex_mem_o.mem_valid      <= live;
      ex_mem_o.mem_op         <= live ? ex_params_i.mem_op : MEM_OP_NONE;
      ex_mem_o.mem_rd_addr    <= ex_params_i.rd_addr;
      // Branches carry their link address; rd_addr = 0 makes the write a no-op.
      ex_mem_o.mem_result     <= ex_params_i.branch ? ex_params_i.ia_plus_4 : alu_result;
      ex_mem_o.mem_store_data <= rb_val;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign t_flag_o         = t_flag_q;

`ifdef EX_PERF_COUNTERS_EN
  logic [31:0] perf_taken_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_taken_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (taken)    perf_taken_q <= perf_taken_q + 32'd1;
      if (!valid_o) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_taken_o = perf_taken_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule
